// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid and data, and the slave drives ready.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 113
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer. Its ready output is registered, and it presents a NOP bubble when empty.
// Optional stall counter: define PIPE_SKID_STATS_EN.
//
// state    | meaning
// ST_EMPTY | no entry held, out_data = BUBBLE
// ST_ONE   | main holds the oldest entry
// ST_TWO   | main and skid both full, in_ready = 0
module pipe_skid_reg #(
  parameter int              DATA_W = 113,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_skid_reg_if.slave         up,
  pipe_skid_reg_if.master        dn,
  output logic [1:0]             occupancy
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  // The state encoding equals the entry count, so occupancy falls straight out of it.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occ_q;
  logic              in_acc;
  logic              out_acc;

  assign in_acc  = up.valid & in_ready_q;
  assign out_acc = out_valid_q & dn.ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_acc) begin
            main_d  = up.data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_acc, out_acc})
            2'b11: main_d = up.data;
            2'b10: begin
              skid_d  = up.data;
              state_d = ST_TWO;
            end
            2'b01: begin
              main_d  = BUBBLE;
              state_d = ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (out_acc) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= state_d;
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid_q;
  assign dn.data   = main_q;
  assign occupancy = occ_q;

`ifdef PIPE_SKID_STATS_EN
  // Counts downstream backpressure cycles and saturates at the maximum. A flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
    end else if (out_valid_q && !dn.ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
